// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: interrupt front end for the 6502C core.
// Synchronises NMI/IRQ pins, latches NMI edges, arbitrates NMI > IRQ > BRK
// (reset handled as its own sequence) and drives brkNow/vecSel/bFlag into the
// PLA timing FSM until it returns intHandled.
// Optional macro INT_COUNT_EN adds a saturating 16-bit serviced-interrupt count.
module interrupt_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       phi1,
  input  logic       rst,
  input  logic       RDY,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       Iflag,
  input  logic       brkOp,
  input  logic       fetchT1,
  input  logic       intHandled,
  output logic       brkNow,
  output logic [1:0] vecSel,
  output logic       bFlag,
  output logic       nmiPend
`ifdef INT_COUNT_EN
  ,
  output logic [15:0] intCount
`endif
);

  typedef enum logic [1:0] {RSTSEQ, IDLE, SERVICE} state_t;
  typedef enum logic [1:0] {SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

  localparam logic [1:0] VEC_NONE = 2'd0;
  localparam logic [1:0] VEC_NMI  = 2'd1;
  localparam logic [1:0] VEC_RST  = 2'd2;
  localparam logic [1:0] VEC_IRQ  = 2'd3;

  logic [SYNC_STAGES-1:0] nmi_sync_q, irq_sync_q;
  logic                   nmi_prev_q;
  logic                   nmi_pend_q, nmi_pend_d;
  state_t                 state_q;
  src_t                   src_q;
  logic                   brk_now_q, b_flag_q;
  logic [1:0]             vec_sel_q;

  logic nmi_s, irq_s, nmi_edge, irq_req, take, done;

  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign irq_s    = irq_sync_q[SYNC_STAGES-1];
  assign nmi_edge = nmi_prev_q & ~nmi_s;
  assign irq_req  = ~irq_s & ~Iflag;
  // A service starts or retires only on ready cycles.
  assign take     = RDY & (state_q == IDLE) & fetchT1;
  assign done     = RDY & (state_q == SERVICE) & intHandled;

  // Pin synchronisers and NMI edge history; free-running, preset to inactive.
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_n};
      nmi_prev_q <= nmi_s;
    end
  end

  // Pending NMI: a new edge beats a same-cycle retire so no edge is lost.
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if (nmi_edge)
      nmi_pend_d = 1'b1;
    else if (done && src_q == SRC_NMI)
      nmi_pend_d = 1'b0;
  end

  // NMI pending flag register; set path ignores RDY.
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) nmi_pend_q <= 1'b0;
    else     nmi_pend_q <= nmi_pend_d;
  end

  // Arbitration FSM with registered outputs; frozen while RDY is low.
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      state_q   <= RSTSEQ;
      src_q     <= SRC_BRK;
      brk_now_q <= 1'b0;
      vec_sel_q <= VEC_RST;
      b_flag_q  <= 1'b0;
    end else if (RDY) begin
      unique case (state_q)
        RSTSEQ: begin
          if (intHandled) begin
            state_q   <= IDLE;
            vec_sel_q <= VEC_NONE;
          end
        end
        IDLE: begin
          if (fetchT1) begin
            if (nmi_pend_q) begin
              state_q   <= SERVICE;
              src_q     <= SRC_NMI;
              brk_now_q <= 1'b1;
              vec_sel_q <= VEC_NMI;
              b_flag_q  <= 1'b0;
            end else if (irq_req) begin
              state_q   <= SERVICE;
              src_q     <= SRC_IRQ;
              brk_now_q <= 1'b1;
              vec_sel_q <= VEC_IRQ;
              b_flag_q  <= 1'b0;
            end else if (brkOp) begin
              state_q   <= SERVICE;
              src_q     <= SRC_BRK;
              brk_now_q <= 1'b1;
              vec_sel_q <= VEC_IRQ;
              b_flag_q  <= 1'b1;
            end
          end
        end
        SERVICE: begin
          if (intHandled) begin
            state_q   <= IDLE;
            brk_now_q <= 1'b0;
            vec_sel_q <= VEC_NONE;
            b_flag_q  <= 1'b0;
          end
        end
        default: state_q <= RSTSEQ;
      endcase
    end
  end

  assign brkNow  = brk_now_q;
  assign vecSel  = vec_sel_q;
  assign bFlag   = b_flag_q;
  assign nmiPend = nmi_pend_q;

`ifdef INT_COUNT_EN
  logic [15:0] int_count_q;

  // Count every IDLE->SERVICE entry, saturating at all-ones.
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst)
      int_count_q <= '0;
    else if (take && (nmi_pend_q || irq_req || brkOp) && int_count_q != 16'hFFFF)
      int_count_q <= int_count_q + 16'd1;
  end

  assign intCount = int_count_q;
`else
  logic unused_take;
  assign unused_take = take;
`endif

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Interrupt front end for the 6502C core. Sits directly upstream of the PLA timing FSM.
- Synchronises the external NMI and IRQ pins, latches NMI edges, and arbitrates NMI, IRQ, software BRK and reset.
- Drives brkNow into the FSM and selects the interrupt vector for the address-high/low muxes.
- Retires the request when the FSM returns intHandled.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchroniser (legal: 2 or 3).

Ports:
- phi1  in  1  sole clock; all flops on posedge phi1
- rst  in  1  asynchronous active-high reset
- RDY  in  1  core ready; low freezes arbitration state
- nmi_n  in  1  NMI pin, active-low, edge-triggered, asynchronous
- irq_n  in  1  IRQ pin, active-low, level-sensitive, asynchronous
- Iflag  in  1  status-register interrupt-disable bit
- brkOp  in  1  decoded opcode is BRK; valid when fetchT1 is high
- fetchT1  in  1  core is in its opcode-fetch (T1) cycle
- intHandled  in  1  one-cycle pulse from the FSM: interrupt sequence complete
- brkNow  out  1  force the BRK sequence on the next fetch
- vecSel  out  2  vector: 0=none, 1=NMI $FFFA, 2=RST $FFFC, 3=IRQ/BRK $FFFE
- bFlag  out  1  value of B pushed with P: 1 for BRK, 0 otherwise
- nmiPend  out  1  NMI edge latched, not yet serviced

Behaviour:
- Reset (async, any time, including mid-service):
  - state=RSTSEQ, vecSel=2, brkNow=0, bFlag=0, nmiPend=0.
  - Synchroniser flops preset to 1 (pins inactive).
  - The edge detector's previous-sample flop is also preset to 1.
- Synchroniser: SYNC_STAGES flops per pin; nmi_s and irq_s are the last stage. They run every cycle regardless of RDY.
- NMI edge detect:
  - Condition: nmi_s_prev=1 and nmi_s=0.
  - Sets nmiPend on the following edge, regardless of RDY, so edges are never lost.
  - A held-low NMI produces one edge only.
- irqReq = ~irq_s & ~Iflag (combinational, not latched).
- States: RSTSEQ, IDLE, SERVICE. Transitions are taken only on cycles with RDY=1.
- RSTSEQ:
  - Holds vecSel=2 and brkNow=0.
  - On intHandled, goes to IDLE and sets vecSel=0.
- IDLE, when fetchT1=1, sources are checked in priority order:
  - nmiPend: go to SERVICE with src=NMI (vecSel=1, bFlag=0).
  - else irqReq: go to SERVICE with src=IRQ (vecSel=3, bFlag=0).
  - else brkOp: go to SERVICE with src=BRK (vecSel=3, bFlag=1).
  - In every case brkNow=1 from the next cycle.
  - If fetchT1=0, stay in IDLE.
- SERVICE:
  - brkNow, vecSel and bFlag are held stable.
  - On intHandled: go to IDLE with brkNow=0, vecSel=0, bFlag=0. If src=NMI, clear nmiPend in the same edge.
- Simultaneous NMI edge and intHandled for an NMI service: the set wins, so nmiPend stays 1 and the new NMI is serviced next.
- An NMI edge during an IRQ/BRK SERVICE stays pending. It is taken at the next IDLE fetchT1, with no hijack of the current sequence.
- IRQ deasserted or Iflag set during SERVICE: no effect; the sequence completes.
- intHandled while in IDLE: ignored.
- RDY=0: state, brkNow, vecSel and bFlag hold; the synchronisers and nmiPend set path stay live.
- Latency: pin falling edge to nmiPend = SYNC_STAGES+1 cycles. A pending source at fetchT1 gives brkNow=1 one cycle later.

Optional Feature:
- Macro: INT_COUNT_EN.
- Defined:
  - Adds output intCount [15:0], reset to 0.
  - Increments by 1 on every IDLE->SERVICE transition, whatever the source.
  - Saturates at 16'hFFFF; RDY=0 holds it.
- Undefined: the port and counter are absent, with no other change.

Test Plan:
- Reset then idle: assert rst mid-SERVICE -> vecSel=2, brkNow=0 immediately; intHandled pulse -> vecSel=0, state IDLE.
- NMI edge: nmi_n 1->0 held low 20 cycles, SYNC_STAGES=2 -> nmiPend=1 exactly 3 cycles after the edge. fetchT1 -> brkNow=1, vecSel=1. intHandled -> nmiPend=0, with no second service.
- IRQ masking: irq_n=0, Iflag=1, fetchT1 pulsed -> brkNow stays 0. Clear Iflag, pulse fetchT1 -> brkNow=1, vecSel=3, bFlag=0.
- Priority: nmiPend=1, irq_n=0 and brkOp=1 at the same fetchT1 -> vecSel=1. After intHandled, next fetchT1 -> vecSel=3, bFlag=0.
- NMI during IRQ service: edge arrives in SERVICE(IRQ) -> vecSel stays 3. intHandled -> IDLE; next fetchT1 -> vecSel=1.
- RDY stall: RDY=0 for 5 cycles across an NMI edge and fetchT1 -> no state change, nmiPend=1. RDY=1 with fetchT1 -> brkNow=1. With INT_COUNT_EN, intCount increments 0->1.
